// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: multiply ops complete in one cycle via a combinational product.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        f3;
  logic              neg;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   dvs;
  logic [2*XLEN-1:0] acc;

  // issue-side decode on the raw register-read operands
  logic            sgn_a, sgn_b, sa, sb, neg_in, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sa     = sgn_a & op_a[XLEN-1];
  assign sb     = sgn_b & op_b[XLEN-1];
  assign a_mag  = sa ? -op_a : op_a;
  assign b_mag  = sb ? -op_b : op_b;
  // remainder follows the dividend; product and quotient follow the sign xor
  assign neg_in = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
  assign div0   = funct3[2] && (op_b == '0);
  assign ovf    = funct3[2] && !funct3[0] && (op_a == MIN) && (op_b == '1);
  assign spec_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN);

  assign busy = (state != IDLE);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     msum, dcand, ddiff;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : {(XLEN+1){1'b0}});
    dcand = acc[2*XLEN-1:XLEN-1];
    ddiff = dcand - {1'b0, dvs};
    if (!f3[2])
      acc_nxt = {msum, acc[XLEN-1:1]};
    else if (!ddiff[XLEN])
      acc_nxt = {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {dcand[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  function automatic logic [XLEN-1:0] fix_res(input logic [2:0] f, input logic n,
                                              input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] pn;
    logic [XLEN-1:0]   q, r;
    pn = n ? -p : p;
    q  = n ? -p[XLEN-1:0] : p[XLEN-1:0];
    r  = n ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (!f[2])
      fix_res = (f[1:0] == 2'b00) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];
    else
      fix_res = f[1] ? r : q;
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  assign fprod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f3    <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      dvs   <= '0;
      acc   <= '0;
      we    <= 1'b0;
      rd    <= '0;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          we <= 1'b0;
          if (start) begin
            f3  <= funct3;
            rd  <= rd_in;
            neg <= neg_in;
            cnt <= '0;
            if (div0 || ovf) begin
              wd    <= spec_res;
              we    <= (rd_in != 5'd0);
              acc   <= '0;
              dvs   <= '0;
              state <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!funct3[2]) begin
              wd    <= fix_res(funct3, neg_in, fprod);
              we    <= (rd_in != 5'd0);
              state <= DONE;
            end
`endif
            else begin
              dvs   <= funct3[2] ? b_mag : a_mag;
              acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (cnt == CW'(XLEN-1)) begin
            wd    <= fix_res(f3, neg, acc_nxt);
            we    <= (rd != 5'd0);
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          we    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
